// File: rtl/bw_mac_accumulator.sv
// Signed 4x4 Baugh-Wooley multiply-accumulate stage: N_TERMS products per batch, valid/ready in and out.
// Optional macro BW_MAC_SAT_EN: saturating accumulator with sticky ovf; otherwise wraps and ovf = 0.

module BW_Multiplier (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0][3:0] pp;
    logic [7:0]      tot;

    // Rows/columns touching exactly one sign bit are inverted; the 0x90 seed restores the weights.
    for (genvar i = 0; i < 4; i++) begin : g_row
        for (genvar j = 0; j < 4; j++) begin : g_col
            if ((i == 3) != (j == 3)) begin : g_inv
                assign pp[i][j] = ~(a[i] & b[j]);
            end else begin : g_pos
                assign pp[i][j] = a[i] & b[j];
            end
        end
    end

    always_comb begin
        tot = 8'h90;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                tot = tot + ({7'd0, pp[i][j]} << (i + j));
            end
        end
    end

    assign p = tot;
endmodule

module bw_mac_accumulator #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf
);
    localparam int CNT_W = $clog2(N_TERMS + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        issue_cnt, issue_nxt;
    logic [CNT_W-1:0]        term_cnt;
    logic [3:0]              a_q, b_q;
    logic                    v1;
    logic [7:0]              p;
    logic signed [ACC_W-1:0] sext_p;
    logic [ACC_W-1:0]        acc, acc_add, acc_nxt;
    logic                    ovf_q, ovf_set;
    logic                    in_ready_q, in_ready_nxt;
    logic                    accept, handshake, last_term;

    BW_Multiplier u_mul (
        .a (a_q),
        .b (b_q),
        .p (p)
    );

    assign accept    = in_valid && in_ready_q;
    assign handshake = out_valid && out_ready;
    assign last_term = v1 && (term_cnt == CNT_W'(N_TERMS - 1));
    assign sext_p    = ACC_W'($signed(p));

`ifdef BW_MAC_SAT_EN
    logic [ACC_W:0] add_wide;

    assign add_wide = {acc[ACC_W-1], acc} + {sext_p[ACC_W-1], sext_p};

    // Top two bits disagree only on signed overflow; the top bit carries the true sign.
    always_comb begin
        acc_add = add_wide[ACC_W-1:0];
        ovf_set = 1'b0;
        if (add_wide[ACC_W] != add_wide[ACC_W-1]) begin
            ovf_set = 1'b1;
            acc_add = add_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign acc_add = acc + sext_p;
    assign ovf_set = 1'b0;
`endif

    // First term of a batch loads directly, so no clear bubble is needed between batches.
    assign acc_nxt = (term_cnt == '0) ? sext_p : acc_add;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = ACCUM;
            ACCUM:   if (last_term) state_nxt = DONE;
            DONE:    if (handshake) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clear) state_nxt = IDLE;
    end

    always_comb begin
        issue_nxt = issue_cnt;
        if (handshake)   issue_nxt = '0;
        else if (accept) issue_nxt = issue_cnt + 1'b1;
        in_ready_nxt = (state_nxt != DONE) && (issue_nxt < CNT_W'(N_TERMS));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_cnt  <= '0;
            term_cnt   <= '0;
            acc        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            v1         <= 1'b0;
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b0;
        end else if (clear) begin
            issue_cnt  <= '0;
            term_cnt   <= '0;
            acc        <= '0;
            v1         <= 1'b0;
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            v1         <= accept;
            issue_cnt  <= issue_nxt;
            in_ready_q <= in_ready_nxt;
            if (accept) begin
                a_q <= a;
                b_q <= b;
            end
            if (handshake) begin
                acc      <= '0;
                term_cnt <= '0;
                ovf_q    <= 1'b0;
            end else if (v1) begin
                acc      <= acc_nxt;
                term_cnt <= term_cnt + 1'b1;
                ovf_q    <= ovf_q | (ovf_set && (term_cnt != '0));
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state == DONE);
    assign sum       = acc;
    assign ovf       = ovf_q;
endmodule
